dmem_port_arbiter: RTL and testbench

//   Shares the single-port data memory (dm0) of data_path between two requesters:
//   - the core load/store unit (port C);
//   - a debug/loader port (port D) used by benches and boot code to preload or dump RAM.

---
 rtl/dmem_port_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
// dmem_port_arbiter: shares one sync-read data memory between the core (C) and debug (D) ports.
// Latency: req sampled at edge N, mem_en in cycle N+1, ack in N+2; one access every 3 cycles.
// Backpressure: requesters hold req until ack, core sees c_stall; `DMEM_ARB_RR_EN selects round-robin over fixed C priority.
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic              owner;       // 0 = core, 1 = debug
    logic              grant_d;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;                   // port that wins the next tie: 0 = core, 1 = debug

    assign grant_d = d_req & (~c_req | rr_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (state == RESP) begin
            rr_ptr <= ~owner;
        end
    end
`else
    assign grant_d = d_req & ~c_req;
`endif

    // The mem address/data registers double as the request latch; they are zeroed outside ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            c_ack     <= 1'b0;
            d_ack     <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_req || d_req) begin
                        owner     <= grant_d;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d ? d_we    : c_we;
                        mem_addr  <= grant_d ? d_addr  : c_addr;
                        mem_wdata <= grant_d ? d_wdata : c_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    c_ack     <= ~owner;
                    d_ack     <= owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (owner) begin
                        d_rdata_q <= mem_rdata;
                    end else begin
                        c_rdata_q <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sync-read data only arrives in RESP, so the ack cycle forwards it ahead of the capture.
    assign c_rdata = c_ack ? mem_rdata : c_rdata_q;
    assign d_rdata = d_ack ? mem_rdata : d_rdata_q;
    assign c_stall = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_port_arbiter: directed steps with a sync-read RAM model and an ack scoreboard.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic [31:0] c_rdata;
    logic        c_ack, c_stall;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        owner;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [256];
    logic [31:0] ram [256];
    bit          ram_ready = 1'b0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] iv;
        iv = 32'(i);
        return 32'hA500_0000 ^ {iv[7:0], iv[7:0], iv[7:0], iv[7:0]};
    endfunction

    // Synchronous-read RAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] = init_val(i);
            ram_ready = 1'b1;
        end
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] = mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_acc(input logic port, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.owner = port;
        e.chk   = !we;
        e.rdata = mdl[addr[9:2]];
        sb.push_back(e);
        if (we) mdl[addr[9:2]] = wdata;
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
        end
    endtask

    task automatic take_ack();
        exp_t e;
        chkb("single_ack", c_ack & d_ack, 1'b0);
        chkb("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chkb("ack_owner", d_ack, e.owner);
            if (e.chk) chk("ack_rdata", e.owner ? d_rdata : c_rdata, e.rdata);
        end
    endtask

    task automatic run_access(input logic port, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int got;
        got = 0;
        @(negedge clk);
        drive(port, 1'b1, we, addr, wdata);
        expect_acc(port, we, addr, wdata);
        #1;
        chkb("stall_req_cycle", c_stall, !port);
        chkb("mem_en_req_cycle", mem_en, 1'b0);
        for (int k = 1; k <= 8 && got == 0; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                chkb("mem_en", mem_en, k == 1);
                chkb("mem_we", mem_we, (k == 1) ? we : 1'b0);
                chk("mem_addr", mem_addr, (k == 1) ? addr : 32'h0);
                chk("mem_wdata", mem_wdata, (k == 1) ? wdata : 32'h0);
                chkb("c_stall", c_stall, !port && k == 1);
            end
            if (c_ack || d_ack) begin
                got = k;
                take_ack();
                drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        if (got == 0) drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("ack_latency", 32'(got), 32'd2);
        @(negedge clk);
        chkb("ack_one_cycle", c_ack | d_ack, 1'b0);
        if (!we) chk("rdata_hold", port ? d_rdata : c_rdata, mdl[addr[9:2]]);
    endtask

    initial begin
        int  acks;
        bit  any_ack;
        for (int i = 0; i < 256; i++) mdl[i] = init_val(i);

        // Reset state
        repeat (2) @(negedge clk);
        chkb("rst_c_ack", c_ack, 1'b0);
        chkb("rst_d_ack", d_ack, 1'b0);
        chkb("rst_mem_en", mem_en, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chkb("rst_c_stall", c_stall, 1'b0);
        rst = 1'b0;

        // Reset asserted while a debug write sits in ISSUE
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        chkb("issue_mem_en", mem_en, 1'b1);
        chk("issue_mem_addr", mem_addr, 32'h8);
        rst = 1'b1;
        #1;
        chkb("midrst_mem_en", mem_en, 1'b0);
        chkb("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chkb("midrst_d_ack", d_ack, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack || c_ack || mem_en) any_ack = 1'b1;
        end
        chkb("abandoned_no_ack", any_ack, 1'b0);

        // Debug write then core load of the same word
        run_access(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b0, 32'h10, 32'h0);
        chk("core_load_value", c_rdata, 32'hDEAD_BEEF);

        // Core store
        run_access(1'b0, 1'b1, 32'h0, 32'h0000_1234);

        // Both ports held for four transactions
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
`ifdef DMEM_ARB_RR_EN
        expect_acc(1'b0, 1'b0, 32'h10, 32'h0);
        expect_acc(1'b1, 1'b0, 32'h4, 32'h0);
        expect_acc(1'b0, 1'b0, 32'h10, 32'h0);
        expect_acc(1'b1, 1'b0, 32'h4, 32'h0);
`else
        repeat (4) expect_acc(1'b0, 1'b0, 32'h10, 32'h0);
`endif
        acks = 0;
        for (int k = 0; k < 24 && acks < 4; k++) begin
            @(negedge clk);
            if (c_ack || d_ack) begin
                take_ack();
                acks++;
                if (acks == 4) begin
                    c_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        c_req = 1'b0;
        d_req = 1'b0;
        chk("contention_acks", 32'(acks), 32'd4);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        any_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (c_ack || d_ack) any_ack = 1'b1;
        end
        chkb("dropped_req_no_ack", any_ack, 1'b0);

        // Debug read while the core is idle
        run_access(1'b1, 1'b0, 32'h4, 32'h0);
        chk("d_read_value", d_rdata, mdl[1]);
        chk("c_rdata_untouched", c_rdata, mdl[4]);
        chkb("c_stall_idle", c_stall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
